vector_uram_stream: RTL

//  Parametrised successor to the single-word vector URAM store.

---
 rtl/vector_pkg.sv | 20 ++
 rtl/vector_skid_fifo.sv | 52 +++++
 rtl/vector_uram_stream.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/vector_pkg.sv
// Shared encodings and default geometry for the vector URAM stream block.
package vector_pkg;

    localparam int unsigned DEF_WIDTH  = 256;
    localparam int unsigned DEF_ELEM_W = 32;
    localparam int unsigned DEF_DEPTH  = 64;
    localparam int unsigned DEF_LAT    = 2;

    localparam logic [1:0] MOD_RAW   = 2'd0;
    localparam logic [1:0] MOD_ROTUP = 2'd1;
    localparam logic [1:0] MOD_ROTDN = 2'd2;
    localparam logic [1:0] MOD_BCAST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/vector_skid_fifo.sv
// Small synchronous FIFO absorbing read-pipeline words under output backpressure.
// Head reads as zero when empty so the stream output idles at zero.
module vector_skid_fifo
    import vector_pkg::*;
#(
    parameter int unsigned W     = 257,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointers and occupancy; flushed by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_data;
    end

    assign head = (count != '0) ? store[rd_ptr] : '0;

endmodule

// File: rtl/vector_uram_stream.sv
// Vector store with a credit-controlled burst read engine and per-burst lane transform
// streamed over valid/ready.
module vector_uram_stream
    import vector_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned ELEM_W = DEF_ELEM_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned LAT    = DEF_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W:0]   rd_len,
    input  logic [1:0]        mod,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out,
    output logic              out_last
);

    localparam int unsigned LANES  = WIDTH / ELEM_W;
    localparam int unsigned FIFO_D = LAT + 2;
    localparam int unsigned CNT_W  = $clog2(FIFO_D + 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  pipe_data [LAT];
    logic [LAT-1:0]    pipe_vld;
    logic [LAT-1:0]    pipe_last;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W:0]   issue_left;
    logic [1:0]        mod_q;
    logic              accept_c;
    logic              issue_c;
    logic              pop_c;
    logic              credit_c;
    logic [CNT_W:0]    occ_c;
    logic [CNT_W-1:0]  fifo_count;
    logic [WIDTH:0]    fifo_head;
    logic [WIDTH-1:0]  head_data;

    // Words already in the read pipe hold a FIFO slot, so the FIFO cannot overflow.
    assign occ_c    = (CNT_W+1)'(fifo_count) + (CNT_W+1)'($countones(pipe_vld));
    assign credit_c = occ_c < (CNT_W+1)'(FIFO_D);
    assign pop_c    = out_valid && out_ready;

    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        issue_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd_start && rd_len != '0) begin
                    accept_c   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (credit_c) begin
                    issue_c = 1'b1;
                    if (issue_left == (ADDR_W+1)'(1)) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop_c && out_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            issue_addr <= '0;
            issue_left <= '0;
            mod_q      <= MOD_RAW;
            pipe_vld   <= '0;
            pipe_last  <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
            if (accept_c) begin
                issue_addr <= rd_addr;
                issue_left <= rd_len;
                mod_q      <= mod;
            end else if (issue_c) begin
                issue_addr <= issue_addr + 1'b1;
                issue_left <= issue_left - 1'b1;
            end
            pipe_vld[0]  <= issue_c;
            pipe_last[0] <= issue_c && (issue_left == (ADDR_W+1)'(1));
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

    // Array plus output registers; the read samples pre-write contents (read-first).
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= data_in;
        pipe_data[0] <= mem[issue_addr];
        for (int unsigned i = 1; i < LAT; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    vector_skid_fifo #(
        .W     (WIDTH + 1),
        .DEPTH (FIFO_D),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_vld[LAT-1]),
        .push_data ({pipe_last[LAT-1], pipe_data[LAT-1]}),
        .pop       (pop_c),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign out_last  = fifo_head[WIDTH];
    assign head_data = fifo_head[WIDTH-1:0];

    // Lane transform on the FIFO head; mode is stable for the whole burst.
    always_comb begin
        int unsigned src;
        out = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            src = k;
            case (mod_q)
                MOD_ROTUP: src = (k + LANES - 1) % LANES;
                MOD_ROTDN: src = (k + 1) % LANES;
                MOD_BCAST: src = 0;
                default:   src = k;
            endcase
            out[k*ELEM_W +: ELEM_W] = head_data[src*ELEM_W +: ELEM_W];
        end
    end

endmodule
